// File: rtl/bt_pkg.sv
// Shared widths, depth and word types for the burst register-file memory.
package bt_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 8;
  localparam int STRIDE_LEN = 8;
  localparam int BURST_LEN  = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int BEAT_WIDTH = $clog2(BURST_LEN);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRIDE_LEN-1:0] stride_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  // Beat index at which an over-long burst wraps its address back to zero.
  localparam beat_t BEAT_LAST = beat_t'(BURST_LEN - 1);

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: picks addr_top or last address plus stride each cycle.
// Defining BURST_ASSERT_EN adds overrun and wrap-address assertions.
module burst_addr_gen
  import bt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  burst_en,
  input  logic [ADDR_WIDTH-1:0] addr_top,
  input  logic [STRIDE_LEN-1:0] stride,
  output logic [ADDR_WIDTH-1:0] eff_addr
);

  logic  burst_q;
  addr_t last_addr;
  beat_t beat;
  beat_t beat_next;

  // Only the low address bits of the stride matter since addresses wrap modulo DEPTH.
  logic  unused_stride_hi;
  assign unused_stride_hi = ^stride[STRIDE_LEN-1:ADDR_WIDTH];

  always_comb begin
    eff_addr  = addr_top;
    beat_next = '0;
    if (burst_en && burst_q) begin
      if (beat == BEAT_LAST) begin
        eff_addr = '0;
      end else begin
        eff_addr  = last_addr + stride[ADDR_WIDTH-1:0];
        beat_next = beat + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q   <= 1'b0;
      last_addr <= '0;
      beat      <= '0;
    end else begin
      burst_q   <= burst_en;
      last_addr <= eff_addr;
      beat      <= beat_next;
    end
  end

`ifdef BURST_ASSERT_EN
  logic wrap;
  assign wrap = burst_en && burst_q && (beat == BEAT_LAST);

  overrun_a: assert property (@(posedge clk) disable iff (rst) !wrap)
    else $error("burst overrun");

  wrap_addr_a: assert property (@(posedge clk) disable iff (rst) wrap |-> (eff_addr == '0))
    else $error("burst wrap address not zero");
`endif

endmodule

// File: rtl/burst_txn_top.sv
// Single-port register-file memory fed by the burst address generator.
// Optional assertions are enabled with BURST_ASSERT_EN (see burst_addr_gen).
module burst_txn_top
  import bt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  burst_en,
  input  logic [ADDR_WIDTH-1:0] addr_top,
  input  logic [STRIDE_LEN-1:0] stride,
  input  logic                  wren,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  addr_t eff_addr;
  data_t mem [DEPTH];

  burst_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .burst_en (burst_en),
    .addr_top (addr_top),
    .stride   (stride),
    .eff_addr (eff_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wren) begin
      mem[eff_addr] <= wr_data;
    end
  end

  // A simultaneous write takes priority, so the read port simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rden && !wren) begin
      rd_data <= mem[eff_addr];
    end
  end

endmodule

// File: tb/tb_burst_txn_top.sv
// Table-driven self-checking bench for burst_txn_top, plus a reset-mid-burst sequence.
module tb_burst_txn_top;

  logic       clk;
  logic       rst;
  logic       burst_en;
  logic [4:0] addr_top;
  logic [7:0] stride;
  logic       wren;
  logic       rden;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic       burst;
    logic       wr;
    logic       rd;
    logic [4:0] addr;
    logic [7:0] strd;
    logic [7:0] data;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  burst_txn_top dut (
    .clk      (clk),
    .rst      (rst),
    .burst_en (burst_en),
    .addr_top (addr_top),
    .stride   (stride),
    .wren     (wren),
    .rden     (rden),
    .wr_data  (wr_data),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(string name, logic b, logic w, logic r, logic [4:0] a,
                                 logic [7:0] s, logic [7:0] d, logic c, logic [7:0] e);
    vec_t v;
    v.name = name; v.burst = b; v.wr = w; v.rd = r; v.addr = a;
    v.strd = s; v.data = d; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    burst_en = v.burst;
    wren     = v.wr;
    rden     = v.rd;
    addr_top = v.addr;
    stride   = v.strd;
    wr_data  = v.data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    checks++;
    if (rd_data !== exp) begin
      failures++;
      $display("[TB] FAIL %s: rd_data=0x%02h expected 0x%02h", name, rd_data, exp);
    end
  endtask

  initial begin
    rst = 1'b1; burst_en = 0; addr_top = '0; stride = '0;
    wren = 0; rden = 0; wr_data = '0;
    checks = 0; failures = 0;

    // Reset state and post-reset reads of cleared memory.
    addVec("rst_rd0",  0, 0, 1, 5'h00, 8'h00, 8'h00, 1, 8'h00);
    addVec("rst_rd5",  0, 0, 1, 5'h05, 8'h00, 8'h00, 1, 8'h00);
    addVec("rst_rd31", 0, 0, 1, 5'h1F, 8'h00, 8'h00, 1, 8'h00);
    // Single-beat writes then reads.
    for (int i = 1; i <= 6; i++)
      addVec("sw", 0, 1, 0, 5'(i), 8'h00, 8'(8'h10 + i), 0, 8'h00);
    for (int i = 1; i <= 6; i++)
      addVec("sr", 0, 0, 1, 5'(i), 8'h00, 8'h00, 1, 8'(8'h10 + i));
    // Burst write stride 4 from 7; addr_top changes after beat 1 and must be ignored.
    addVec("bw1", 1, 1, 0, 5'h07, 8'h04, 8'h17, 0, 8'h00);
    addVec("bw2", 1, 1, 0, 5'h1F, 8'h04, 8'h18, 0, 8'h00);
    addVec("bw3", 1, 1, 0, 5'h1F, 8'h04, 8'h19, 0, 8'h00);
    addVec("bw4", 1, 1, 0, 5'h1F, 8'h04, 8'h1A, 0, 8'h00);
    addVec("idle", 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    addVec("bw_rd07", 0, 0, 1, 5'h07, 8'h00, 8'h00, 1, 8'h17);
    addVec("bw_rd0B", 0, 0, 1, 5'h0B, 8'h00, 8'h00, 1, 8'h18);
    addVec("bw_rd0F", 0, 0, 1, 5'h0F, 8'h00, 8'h00, 1, 8'h19);
    addVec("bw_rd13", 0, 0, 1, 5'h13, 8'h00, 8'h00, 1, 8'h1A);
    addVec("bw_rd1F", 0, 0, 1, 5'h1F, 8'h00, 8'h00, 1, 8'h00);
    // Burst read, one-cycle latency per beat.
    addVec("br1", 1, 0, 1, 5'h07, 8'h04, 8'h00, 1, 8'h17);
    addVec("br2", 1, 0, 1, 5'h00, 8'h04, 8'h00, 1, 8'h18);
    addVec("br3", 1, 0, 1, 5'h00, 8'h04, 8'h00, 1, 8'h19);
    addVec("br4", 1, 0, 1, 5'h00, 8'h04, 8'h00, 1, 8'h1A);
    addVec("idle", 0, 0, 0, 5'h00, 8'h00, 8'h00, 1, 8'h1A);
    // Overrun: beats 5..7 wrap to 0, 4, 8.
    addVec("ov1", 1, 1, 0, 5'h07, 8'h04, 8'h17, 0, 8'h00);
    addVec("ov2", 1, 1, 0, 5'h07, 8'h04, 8'h18, 0, 8'h00);
    addVec("ov3", 1, 1, 0, 5'h07, 8'h04, 8'h19, 0, 8'h00);
    addVec("ov4", 1, 1, 0, 5'h07, 8'h04, 8'h1A, 0, 8'h00);
    addVec("ov5", 1, 1, 0, 5'h07, 8'h04, 8'h1B, 0, 8'h00);
    addVec("ov6", 1, 1, 0, 5'h07, 8'h04, 8'h2B, 0, 8'h00);
    addVec("ov7", 1, 1, 0, 5'h07, 8'h04, 8'h3B, 0, 8'h00);
    addVec("idle", 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    addVec("ov_rd00", 0, 0, 1, 5'h00, 8'h00, 8'h00, 1, 8'h1B);
    addVec("ov_rd04", 0, 0, 1, 5'h04, 8'h00, 8'h00, 1, 8'h2B);
    addVec("ov_rd08", 0, 0, 1, 5'h08, 8'h00, 8'h00, 1, 8'h3B);
    addVec("ov_rd13", 0, 0, 1, 5'h13, 8'h00, 8'h00, 1, 8'h1A);
    // Write wins over read; rd_data holds, and holds when idle.
    addVec("prio_wr", 0, 1, 1, 5'h02, 8'h00, 8'h55, 1, 8'h1A);
    addVec("prio_rd", 0, 0, 1, 5'h02, 8'h00, 8'h00, 1, 8'h55);
    addVec("hold",    0, 0, 0, 5'h09, 8'h00, 8'h00, 1, 8'h55);
    // Stride 0x24 from 0x1E: second beat lands at 0x02.
    addVec("wr1", 1, 1, 0, 5'h1E, 8'h24, 8'hA1, 0, 8'h00);
    addVec("wr2", 1, 1, 0, 5'h1E, 8'h24, 8'hA2, 0, 8'h00);
    addVec("idle", 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    addVec("wrap_rd02", 0, 0, 1, 5'h02, 8'h00, 8'h00, 1, 8'hA2);
    addVec("wrap_rd1E", 0, 0, 1, 5'h1E, 8'h00, 8'h00, 1, 8'hA1);
    // One-cycle gap ends a burst; the next starts afresh at addr_top.
    addVec("g1", 1, 1, 0, 5'h10, 8'h01, 8'hC1, 0, 8'h00);
    addVec("g2", 1, 1, 0, 5'h10, 8'h01, 8'hC2, 0, 8'h00);
    addVec("gap", 0, 0, 0, 5'h00, 8'h01, 8'h00, 0, 8'h00);
    addVec("g3", 1, 1, 0, 5'h18, 8'h01, 8'hC3, 0, 8'h00);
    addVec("g4", 1, 1, 0, 5'h18, 8'h01, 8'hC4, 0, 8'h00);
    addVec("idle", 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    addVec("gap_rd11", 0, 0, 1, 5'h11, 8'h00, 8'h00, 1, 8'hC2);
    addVec("gap_rd18", 0, 0, 1, 5'h18, 8'h00, 8'h00, 1, 8'hC3);
    addVec("gap_rd19", 0, 0, 1, 5'h19, 8'h00, 8'h00, 1, 8'hC4);
    addVec("gap_rd12", 0, 0, 1, 5'h12, 8'h00, 8'h00, 1, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rd_data", 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (vecs[i].chk) checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Reset in the middle of a burst aborts it and clears memory.
    @(negedge clk);
    burst_en = 1; wren = 1; rden = 0; addr_top = 5'h0C; stride = 8'h01; wr_data = 8'hE1;
    @(negedge clk);
    wr_data = 8'hE2;
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("midburst_rst_rd_data", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    addr_top = 5'h14; wr_data = 8'hD1;
    @(negedge clk);
    burst_en = 0; wren = 0; rden = 1; addr_top = 5'h14;
    @(posedge clk); #1;
    checkOutput("post_rst_rd14", 8'hD1);
    @(negedge clk);
    addr_top = 5'h0D;
    @(posedge clk); #1;
    checkOutput("post_rst_rd0D", 8'h00);
    @(negedge clk);
    addr_top = 5'h00;
    @(posedge clk); #1;
    checkOutput("post_rst_rd00", 8'h00);
    @(negedge clk);
    addr_top = 5'h01;
    @(posedge clk); #1;
    checkOutput("post_rst_rd01", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
